// File: rtl/snake_score_counter.sv
// Snake game score counter. It accumulates a packed 4-digit BCD score and tracks the session high score.
// It also drives the scoreboard display value and blinks score/high score after game over.
module snake_score_counter #(
   parameter int SCORE_WIDTH  = 16,
   parameter int POINTS       = 1,
   parameter int BLINK_CYCLES = 50000000
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic                   i_Start,
   input  logic                   i_Eat,
   input  logic                   i_GameOver,
   output logic [SCORE_WIDTH-1:0] o_Score,
   output logic [SCORE_WIDTH-1:0] o_HighScore,
   output logic [SCORE_WIDTH-1:0] o_Display,
   output logic [1:0]             o_State,
   output logic                   o_NewHigh
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_PLAY = 2'b01;
   localparam logic [1:0] ST_OVER = 2'b10;

   localparam int              CNT_W    = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
   localparam logic [4:0]      PTS      = 5'(POINTS);

   logic [1:0]             r_State;
   logic [SCORE_WIDTH-1:0] r_Score;
   logic [SCORE_WIDTH-1:0] r_High;
   logic [SCORE_WIDTH-1:0] r_Display;
   logic                   r_NewHigh;
   logic [CNT_W-1:0]       r_Cnt;
   logic                   r_Phase;

   logic [1:0]             w_NState;
   logic [SCORE_WIDTH-1:0] w_NScore;
   logic [SCORE_WIDTH-1:0] w_NHigh;
   logic [SCORE_WIDTH-1:0] w_NDisplay;
   logic                   w_NNewHigh;
   logic [CNT_W-1:0]       w_NCnt;
   logic                   w_NPhase;
   logic [SCORE_WIDTH-1:0] w_Sum;
   logic [SCORE_WIDTH-1:0] w_Added;
   logic                   w_CarryOut;

   // Ripple decimal carry through all four digits; a carry out of the top digit means saturation.
   always_comb begin : bcd_add
      logic [4:0] v_dig;
      logic       v_c;
      v_c   = 1'b0;
      v_dig = '0;
      w_Sum = '0;
      for (int d = 0; d < 4; d++) begin
         v_dig = {1'b0, r_Score[4*d +: 4]} + ((d == 0) ? PTS : 5'd0) + {4'd0, v_c};
         if (v_dig > 5'd9) begin
            w_Sum[4*d +: 4] = 4'(v_dig - 5'd10);
            v_c             = 1'b1;
         end else begin
            w_Sum[4*d +: 4] = v_dig[3:0];
            v_c             = 1'b0;
         end
      end
      w_CarryOut = v_c;
   end

   assign w_Added = w_CarryOut ? 16'h9999 : w_Sum;

   always_comb begin
      w_NState   = r_State;
      w_NScore   = r_Score;
      w_NHigh    = r_High;
      w_NNewHigh = r_NewHigh;
      w_NCnt     = r_Cnt;
      w_NPhase   = r_Phase;
      case (r_State)
         ST_IDLE: begin
            if (i_Start) begin
               w_NState = ST_PLAY;
               w_NScore = '0;
            end
         end
         ST_PLAY: begin
            if (i_Eat) w_NScore = w_Added;
            // The high-score compare sees the post-add score when eat and game over coincide.
            if (i_GameOver) begin
               w_NState = ST_OVER;
               w_NCnt   = '0;
               w_NPhase = 1'b0;
               if (w_NScore > r_High) begin
                  w_NHigh    = w_NScore;
                  w_NNewHigh = 1'b1;
               end else begin
                  w_NNewHigh = 1'b0;
               end
            end
         end
         ST_OVER: begin
            if (i_Start) begin
               w_NState   = ST_PLAY;
               w_NScore   = '0;
               w_NNewHigh = 1'b0;
               w_NCnt     = '0;
               w_NPhase   = 1'b0;
            end else if (r_Cnt == CNT_LAST) begin
               w_NCnt   = '0;
               w_NPhase = ~r_Phase;
            end else begin
               w_NCnt = r_Cnt + 1'b1;
            end
         end
         default: w_NState = ST_IDLE;
      endcase
   end

   always_comb begin
      w_NDisplay = w_NHigh;
      case (w_NState)
         ST_PLAY: w_NDisplay = w_NScore;
         ST_OVER: w_NDisplay = w_NPhase ? w_NHigh : w_NScore;
         default: w_NDisplay = w_NHigh;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_State   <= ST_IDLE;
         r_Score   <= '0;
         r_High    <= '0;
         r_Display <= '0;
         r_NewHigh <= 1'b0;
         r_Cnt     <= '0;
         r_Phase   <= 1'b0;
      end else begin
         r_State   <= w_NState;
         r_Score   <= w_NScore;
         r_High    <= w_NHigh;
         r_Display <= w_NDisplay;
         r_NewHigh <= w_NNewHigh;
         r_Cnt     <= w_NCnt;
         r_Phase   <= w_NPhase;
      end
   end

   assign o_Score     = r_Score;
   assign o_HighScore = r_High;
   assign o_Display   = r_Display;
   assign o_State     = r_State;
   assign o_NewHigh   = r_NewHigh;

endmodule

// File: tb/tb_snake_score_counter.sv
// Directed bench for snake_score_counter. Two instances share stimulus: POINTS=1 for the main checks
// and POINTS=7 for the saturation check.
module tb_snake_score_counter;

   logic        i_Clk = 1'b0;
   logic        i_Rst, i_Start, i_Eat, i_GameOver;
   logic [15:0] o_Score, o_HighScore, o_Display;
   logic [1:0]  o_State;
   logic        o_NewHigh;
   logic [15:0] o_Score7, o_HighScore7, o_Display7;
   logic [1:0]  o_State7;
   logic        o_NewHigh7;

   int n_vec = 0;
   int n_err = 0;

   always #5 i_Clk = ~i_Clk;

   snake_score_counter #(.SCORE_WIDTH(16), .POINTS(1), .BLINK_CYCLES(4)) u_dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Eat(i_Eat), .i_GameOver(i_GameOver),
      .o_Score(o_Score), .o_HighScore(o_HighScore), .o_Display(o_Display),
      .o_State(o_State), .o_NewHigh(o_NewHigh)
   );

   snake_score_counter #(.SCORE_WIDTH(16), .POINTS(7), .BLINK_CYCLES(4)) u_dut7 (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Eat(i_Eat), .i_GameOver(i_GameOver),
      .o_Score(o_Score7), .o_HighScore(o_HighScore7), .o_Display(o_Display7),
      .o_State(o_State7), .o_NewHigh(o_NewHigh7)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic st, input logic eat, input logic go);
      i_Rst = rst; i_Start = st; i_Eat = eat; i_GameOver = go;
      tick();
      i_Rst = 1'b0; i_Start = 1'b0; i_Eat = 1'b0; i_GameOver = 1'b0;
   endtask

   task automatic eat_n(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      i_Rst = 1'b0; i_Start = 1'b0; i_Eat = 1'b0; i_GameOver = 1'b0;
      #1;
      // 1. reset, then idle ignores eat/game over
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_state",   {14'd0, o_State}, 16'h0000);
      chk("rst_score",   o_Score,          16'h0000);
      chk("rst_high",    o_HighScore,      16'h0000);
      chk("rst_disp",    o_Display,        16'h0000);
      chk("rst_newhigh", {15'd0, o_NewHigh}, 16'h0000);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("idle_state", {14'd0, o_State}, 16'h0000);
      chk("idle_score", o_Score,          16'h0000);
      chk("idle_disp",  o_Display,        16'h0000);

      // 2. BCD carry
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("start_state", {14'd0, o_State}, 16'h0001);
      eat_n(199);
      chk("carry_199",  o_Score,   16'h0199);
      chk("carry_disp", o_Display, 16'h0199);
      eat_n(1);
      chk("carry_200",   o_Score,   16'h0200);
      chk("carry_disp2", o_Display, 16'h0200);

      // 3. saturation (POINTS=7 instance)
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      eat_n(1428);
      chk("sat_9996", o_Score7, 16'h9996);
      eat_n(1);
      chk("sat_1", o_Score7, 16'h9999);
      eat_n(1);
      chk("sat_2", o_Score7, 16'h9999);

      // 4. high score and blink
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      eat_n(12);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("g1_high",    o_HighScore,        16'h0012);
      chk("g1_newhigh", {15'd0, o_NewHigh}, 16'h0001);
      chk("g1_state",   {14'd0, o_State},   16'h0002);
      chk("g1_disp",    o_Display,          16'h0012);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("g2_newhigh_clr", {15'd0, o_NewHigh}, 16'h0000);
      chk("g2_score_clr",   o_Score,            16'h0000);
      eat_n(5);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("g2_high",    o_HighScore,        16'h0012);
      chk("g2_newhigh", {15'd0, o_NewHigh}, 16'h0000);
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("blink_%0d", k), o_Display, ((k / 4) % 2 == 1) ? 16'h0012 : 16'h0005);
         if (k < 11) drive(1'b0, 1'b0, 1'b1, 1'b1);
      end
      chk("over_hold", o_Score, 16'h0005);

      // 5. simultaneous eat + game over at score == high
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      eat_n(12);
      chk("sim_pre", o_Score, 16'h0012);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk("sim_score",   o_Score,            16'h0013);
      chk("sim_high",    o_HighScore,        16'h0013);
      chk("sim_newhigh", {15'd0, o_NewHigh}, 16'h0001);
      chk("sim_state",   {14'd0, o_State},   16'h0002);

      // 6. reset mid-game
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      eat_n(40);
      chk("mid_score", o_Score,     16'h0040);
      chk("mid_high",  o_HighScore, 16'h0013);
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      chk("mrst_state",   {14'd0, o_State},   16'h0000);
      chk("mrst_score",   o_Score,            16'h0000);
      chk("mrst_high",    o_HighScore,        16'h0000);
      chk("mrst_disp",    o_Display,          16'h0000);
      chk("mrst_newhigh", {15'd0, o_NewHigh}, 16'h0000);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("restart_state", {14'd0, o_State}, 16'h0001);
      chk("restart_score", o_Score,          16'h0000);
      eat_n(1);
      chk("restart_eat", o_Score, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/snake_score_counter.md
Name: snake_score_counter

Overview:
- BCD score accumulator and game-score state machine for the snake game.
- Sits directly upstream of snake_scoreboard.
- Counts food-eaten events as packed 4-digit BCD and tracks the session high score.
- Drives o_Display, the value that snake_scoreboard's i_Score input consumes; alternates score/high score after game over.

Parameters:
- SCORE_WIDTH, 16: packed BCD width, four digits, [15:12] most significant. Only 16 is supported.
- POINTS, 1: BCD points added per food event. Legal range 1..9.
- BLINK_CYCLES, 50000000: clock cycles per display phase in OVER state. Must be ≥2.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Start  input  1  single-cycle pulse: start a new game.
- i_Eat  input  1  single-cycle pulse: snake ate food.
- i_GameOver  input  1  single-cycle pulse: collision, game ended.
- o_Score  output  16  current game score, packed BCD.
- o_HighScore  output  16  highest score since reset, packed BCD.
- o_Display  output  16  value to show on the scoreboard, packed BCD.
- o_State  output  2  FSM state: 00 IDLE, 01 PLAYING, 10 OVER. 11 is never produced.
- o_NewHigh  output  1  high when the last finished game set a new high score.

Behaviour:
- Reset (i_Rst=1 at a clock edge, any state, including mid-game):
  - State goes to IDLE.
  - o_Score = 0x0000, o_HighScore = 0x0000, o_Display = 0x0000, o_NewHigh = 0.
  - Blink counter and blink phase cleared.
  - Reset has priority over all other inputs.
- All outputs are registered. Every response below appears on the cycle after the causing edge.
- IDLE:
  - o_Display = o_HighScore.
  - i_Start: go to PLAYING and clear o_Score to 0x0000.
  - i_Eat and i_GameOver are ignored.
- PLAYING:
  - o_Display = o_Score.
  - i_Eat: o_Score ← o_Score + POINTS using BCD addition, with decimal carry rippling through all four digits in one cycle.
    - Example: 0x0199 + 1 = 0x0200.
  - Saturation: if the BCD sum would exceed 9999, o_Score holds 0x9999. No wrap.
  - i_GameOver: go to OVER.
  - i_Eat and i_GameOver on the same edge: the eat is added first, then the transition to OVER is taken. The high-score comparison uses the post-add score.
  - i_Start is ignored.
- Entry to OVER (same edge as the transition):
  - If the final score > o_HighScore: o_HighScore ← final score and o_NewHigh ← 1.
  - Otherwise both are unchanged and o_NewHigh ← 0.
  - Comparison is an unsigned compare of the packed BCD vectors. This is valid because every nibble is always 0..9.
  - Equal score is not a new high.
- OVER:
  - i_Eat and i_GameOver are ignored; o_Score holds.
  - Blink counter counts 0..BLINK_CYCLES-1 and toggles the phase at wrap.
  - Phase 0 (entered on OVER entry): o_Display = o_Score.
  - Phase 1: o_Display = o_HighScore.
  - The first toggle happens BLINK_CYCLES cycles after entry.
  - i_Start: go to PLAYING, o_Score ← 0x0000, o_NewHigh ← 0, blink counter and phase cleared.
- Invariant: every nibble of o_Score, o_HighScore and o_Display is always in 0..9.

Test Plan (bench overrides BLINK_CYCLES=4, POINTS=1 unless stated):
1. Reset then idle:
   - Stimulus: assert i_Rst, then pulse i_Eat and i_GameOver in IDLE.
   - Response: o_State=00, o_Score=0x0000, o_Display=0x0000, o_NewHigh=0; the eat and game-over pulses are ignored.
2. BCD carry:
   - Stimulus: i_Start, then 199 i_Eat pulses, then one more i_Eat.
   - Response: o_Score=0x0199 after the 199 pulses, then 0x0200 on the next cycle; o_Display tracks o_Score.
3. Saturation:
   - Stimulus: POINTS=7, start, pulse i_Eat until the score reaches 0x9996, then pulse i_Eat twice more.
   - Response: o_Score=0x9999 after each of the two extra pulses.
4. High score and blink:
   - Stimulus: game 1 scores 0x0012, then i_GameOver; game 2 scores 0x0005, then i_GameOver.
   - Response after game 1: o_HighScore=0x0012, o_NewHigh=1, o_State=10.
   - Response after game 2: o_HighScore=0x0012, o_NewHigh=0; o_Display = 0x0005 for 4 cycles, then 0x0012 for 4 cycles, repeating.
5. Simultaneous events:
   - Stimulus: score at 0x0012 = high score; i_Eat and i_GameOver on the same cycle.
   - Response: o_Score=0x0013, o_HighScore=0x0013, o_NewHigh=1, o_State=10.
6. Reset mid-game:
   - Stimulus: o_Score=0x0040 with o_HighScore=0x0013 in PLAYING; assert i_Rst for one cycle.
   - Response: all outputs zero, o_State=00 on the next cycle; a subsequent i_Start begins a game from 0x0000.
